// File: rtl/bsg_manycore_pkt_exec_if.sv
// Decoded-packet and store-port bundle for the packet executor.
// slave: executor side; master: decoder/memory side.
interface bsg_manycore_pkt_exec_if #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 8
);
  localparam int mask_width_lp = data_width_p / 8;

  logic                     v_i;
  logic                     yumi_o;
  logic                     pkt_freeze_i;
  logic                     pkt_unfreeze_i;
  logic                     pkt_arb_cfg_i;
  logic                     pkt_remote_store_i;
  logic                     pkt_unknown_i;
  logic [data_width_p-1:0]  data_i;
  logic [addr_width_p-1:0]  addr_i;
  logic [mask_width_lp-1:0] mask_i;

  logic                     mem_v_o;
  logic [addr_width_p-1:0]  mem_addr_o;
  logic [data_width_p-1:0]  mem_data_o;
  logic [mask_width_lp-1:0] mem_mask_o;
  logic                     mem_yumi_i;

  modport slave (
    input  v_i, pkt_freeze_i, pkt_unfreeze_i,
    input  pkt_arb_cfg_i, pkt_remote_store_i,
    input  pkt_unknown_i, data_i, addr_i, mask_i,
    input  mem_yumi_i,
    output yumi_o, mem_v_o, mem_addr_o,
    output mem_data_o, mem_mask_o
  );

  modport master (
    output v_i, pkt_freeze_i, pkt_unfreeze_i,
    output pkt_arb_cfg_i, pkt_remote_store_i,
    output pkt_unknown_i, data_i, addr_i, mask_i,
    output mem_yumi_i,
    input  yumi_o, mem_v_o, mem_addr_o,
    input  mem_data_o, mem_mask_o
  );
endinterface

// File: rtl/bsg_manycore_pkt_exec.sv
// Executes decoded manycore packets: freeze/arb-config registers,
// one-entry remote-store buffer, one credit pulse per completed packet.
// Ports: clk_i, reset_i (async, active-high); pkt_if (slave) carries the
// decoded packet handshake and the store port; freeze_o, arb_cfg_o,
// credit_v_o, err_count_o are status outputs.
// Optional: BSG_MANYCORE_PKT_EXEC_ERR_CNT_EN enables the saturating
// unknown-packet counter on err_count_o (tied to 0 otherwise).
module bsg_manycore_pkt_exec #(
  parameter int   data_width_p    = -1,
  parameter int   addr_width_p    = -1,
  parameter int   arb_cfg_width_p = 2,
  parameter logic freeze_init_p   = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  bsg_manycore_pkt_exec_if.slave     pkt_if,
  output logic                       freeze_o,
  output logic [arb_cfg_width_p-1:0] arb_cfg_o,
  output logic                       credit_v_o,
  output logic [7:0]                 err_count_o
);

  localparam int mask_width_lp = data_width_p / 8;

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                   state_r;
  logic [addr_width_p-1:0]  addr_r;
  logic [data_width_p-1:0]  data_r;
  logic [mask_width_lp-1:0] mask_r;

  logic full, drain, is_store, is_unknown;
  logic yumi, store_acc, ctrl_acc;

  assign full     = (state_r == FULL);
  assign drain    = full & pkt_if.mem_yumi_i;
  assign is_store = pkt_if.pkt_remote_store_i;

  // Any non-store packet without a recognised control flag is unknown,
  // so the explicit unknown flag adds no information.
  assign is_unknown = ~(pkt_if.pkt_freeze_i
                      | pkt_if.pkt_unfreeze_i
                      | pkt_if.pkt_arb_cfg_i);

  // A store may slip in on the cycle the buffered one drains.
  assign yumi = pkt_if.v_i
              & (~full | (drain & is_store));

  assign store_acc = yumi & is_store;
  assign ctrl_acc  = yumi & ~is_store;

  assign pkt_if.yumi_o     = yumi;
  assign pkt_if.mem_v_o    = full;
  assign pkt_if.mem_addr_o = addr_r;
  assign pkt_if.mem_data_o = data_r;
  assign pkt_if.mem_mask_o = mask_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= EMPTY;
      addr_r     <= '0;
      data_r     <= '0;
      mask_r     <= '0;
      freeze_o   <= freeze_init_p;
      arb_cfg_o  <= '0;
      credit_v_o <= 1'b0;
    end else begin
      // ctrl_acc only happens in EMPTY, so never coincides with drain.
      credit_v_o <= drain | ctrl_acc;

      if (store_acc) begin
        state_r <= FULL;
        addr_r  <= pkt_if.addr_i;
        data_r  <= pkt_if.data_i;
        mask_r  <= pkt_if.mask_i;
      end else if (drain) begin
        state_r <= EMPTY;
      end

      if (ctrl_acc) begin
        if (pkt_if.pkt_freeze_i)
          freeze_o <= 1'b1;
        else if (pkt_if.pkt_unfreeze_i)
          freeze_o <= 1'b0;
        else if (pkt_if.pkt_arb_cfg_i)
          arb_cfg_o <= pkt_if.data_i[arb_cfg_width_p-1:0];
      end
    end
  end

  logic unused_unknown_flag;
  assign unused_unknown_flag = pkt_if.pkt_unknown_i;

`ifdef BSG_MANYCORE_PKT_EXEC_ERR_CNT_EN
  logic [7:0] err_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      err_r <= '0;
    else if (ctrl_acc & is_unknown & (err_r != 8'hFF))
      err_r <= err_r + 8'd1;
  end

  assign err_count_o = err_r;
`else
  logic unused_is_unknown;
  assign unused_is_unknown = is_unknown;
  assign err_count_o       = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_pkt_exec.sv
// Directed bench for bsg_manycore_pkt_exec: vector table plus
// hand sequences for saturation and asynchronous reset while FULL.
module tb_bsg_manycore_pkt_exec;

`ifdef BSG_MANYCORE_PKT_EXEC_ERR_CNT_EN
  localparam logic [7:0] EN = 8'd1;
`else
  localparam logic [7:0] EN = 8'd0;
`endif

  localparam logic [4:0] F = 5'b10000;
  localparam logic [4:0] U = 5'b01000;
  localparam logic [4:0] A = 5'b00100;
  localparam logic [4:0] S = 5'b00010;
  localparam logic [4:0] K = 5'b00001;
  localparam logic [4:0] N = 5'b00000;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       freeze_o;
  logic [1:0] arb_cfg_o;
  logic       credit_v_o;
  logic [7:0] err_count_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bsg_manycore_pkt_exec_if #(
    .data_width_p(32), .addr_width_p(8)
  ) ifc ();

  bsg_manycore_pkt_exec #(
    .data_width_p(32), .addr_width_p(8),
    .arb_cfg_width_p(2), .freeze_init_p(1'b1)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .pkt_if     (ifc.slave),
    .freeze_o   (freeze_o),
    .arb_cfg_o  (arb_cfg_o),
    .credit_v_o (credit_v_o),
    .err_count_o(err_count_o)
  );

  typedef struct {
    logic        v;
    logic [4:0]  fl;
    logic [31:0] d;
    logic [7:0]  a;
    logic [3:0]  m;
    logic        my;
    logic        e_yumi;
    logic        e_memv;
    logic        e_frz;
    logic [1:0]  e_arb;
    logic        e_cr;
    logic [7:0]  e_err;
    logic [7:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic v, logic [4:0] fl, logic [31:0] d, logic [7:0] a,
    logic [3:0] m, logic my, logic ey, logic em, logic ef,
    logic [1:0] ea, logic ec, logic [7:0] ee,
    logic [7:0] eaddr, logic [31:0] edata);
    vec_t t;
    t.v = v; t.fl = fl; t.d = d; t.a = a; t.m = m; t.my = my;
    t.e_yumi = ey; t.e_memv = em; t.e_frz = ef; t.e_arb = ea;
    t.e_cr = ec; t.e_err = ee; t.e_addr = eaddr; t.e_data = edata;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [4:0] fl, logic [31:0] d,
                       logic [7:0] a, logic [3:0] m, logic my);
    ifc.v_i                = v;
    ifc.pkt_freeze_i       = fl[4];
    ifc.pkt_unfreeze_i     = fl[3];
    ifc.pkt_arb_cfg_i      = fl[2];
    ifc.pkt_remote_store_i = fl[1];
    ifc.pkt_unknown_i      = fl[0];
    ifc.data_i             = d;
    ifc.addr_i             = a;
    ifc.mask_i             = m;
    ifc.mem_yumi_i         = my;
  endtask

  task automatic apply(vec_t t, int i);
    @(negedge clk);
    drive(t.v, t.fl, t.d, t.a, t.m, t.my);
    #1;
    chk($sformatf("v%0d_yumi", i), 64'(ifc.yumi_o), 64'(t.e_yumi));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_memv", i), 64'(ifc.mem_v_o), 64'(t.e_memv));
    chk($sformatf("v%0d_frz", i), 64'(freeze_o), 64'(t.e_frz));
    chk($sformatf("v%0d_arb", i), 64'(arb_cfg_o), 64'(t.e_arb));
    chk($sformatf("v%0d_cr", i), 64'(credit_v_o), 64'(t.e_cr));
    chk($sformatf("v%0d_err", i), 64'(err_count_o), 64'(t.e_err));
    if (t.e_memv) begin
      chk($sformatf("v%0d_addr", i),
          64'(ifc.mem_addr_o), 64'(t.e_addr));
      chk($sformatf("v%0d_data", i),
          64'(ifc.mem_data_o), 64'(t.e_data));
    end
  endtask

  initial begin
    int ycnt, ccnt;

    tbl.push_back(mk(0,N,0,0,0,0, 0, 0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,U,0,0,0,0, 1, 0,0,0,1,0, 0,0));
    tbl.push_back(mk(1,F,0,0,0,0, 1, 0,1,0,1,0, 0,0));
    tbl.push_back(mk(1,U,0,0,0,0, 1, 0,0,0,1,0, 0,0));
    tbl.push_back(mk(1,S,32'hDEADBEEF,8'h10,4'hF,0, 1,
                     1,0,0,0,0, 8'h10,32'hDEADBEEF));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,S,32'h11111111,8'h20,4'h3,0, 0,
                       1,0,0,0,0, 8'h10,32'hDEADBEEF));
    tbl.push_back(mk(1,S,32'h11111111,8'h20,4'h3,1, 1,
                     1,0,0,1,0, 8'h20,32'h11111111));
    tbl.push_back(mk(0,N,0,0,0,1, 0, 0,0,0,1,0, 0,0));
    tbl.push_back(mk(0,N,0,0,0,0, 0, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,S,1,8'h01,1,0, 1, 1,0,0,0,0, 8'h01,1));
    tbl.push_back(mk(1,S,2,8'h02,1,1, 1, 1,0,0,1,0, 8'h02,2));
    tbl.push_back(mk(1,S,3,8'h03,1,1, 1, 1,0,0,1,0, 8'h03,3));
    tbl.push_back(mk(1,S,4,8'h04,1,1, 1, 1,0,0,1,0, 8'h04,4));
    tbl.push_back(mk(0,N,0,0,0,1, 0, 0,0,0,1,0, 0,0));
    tbl.push_back(mk(1,S,5,8'h05,1,0, 1, 1,0,0,0,0, 8'h05,5));
    tbl.push_back(mk(1,A,3,0,0,1, 0, 0,0,0,1,0, 0,0));
    tbl.push_back(mk(1,A,3,0,0,0, 1, 0,0,3,1,0, 0,0));
    tbl.push_back(mk(0,N,0,0,0,0, 0, 0,0,3,0,0, 0,0));
    tbl.push_back(mk(1,N,0,0,0,0, 1, 0,0,3,1,EN, 0,0));
    tbl.push_back(mk(1,F|U,0,0,0,0, 1, 0,1,3,1,EN, 0,0));
    tbl.push_back(mk(1,A,6,0,0,0, 1, 0,1,2,1,EN, 0,0));

    reset_i = 1'b1;
    drive(0, N, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_frz", 64'(freeze_o), 64'd1);
    chk("rst_arb", 64'(arb_cfg_o), 64'd0);
    chk("rst_memv", 64'(ifc.mem_v_o), 64'd0);
    chk("rst_cr", 64'(credit_v_o), 64'd0);
    chk("rst_err", 64'(err_count_o), 64'd0);
    chk("rst_addr", 64'(ifc.mem_addr_o), 64'd0);
    reset_i = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i);

    ycnt = 0;
    ccnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1, K, 32'(i), 0, 0, 0);
      #1;
      if (ifc.yumi_o) ycnt++;
      @(posedge clk);
      #1;
      if (credit_v_o) ccnt++;
    end
    chk("unk_yumi", 64'(ycnt), 64'd300);
    chk("unk_cred", 64'(ccnt), 64'd300);
    chk("unk_err", 64'(err_count_o), 64'(8'd255 & {8{EN[0]}}));
    @(negedge clk);
    drive(0, N, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("unk_cr_end", 64'(credit_v_o), 64'd0);

    apply(mk(1,U,0,0,0,0, 1, 0,0,2,1,8'd255 & {8{EN[0]}}, 0,0), 100);
    apply(mk(1,S,32'hCAFE,8'h33,4'h1,0, 1,
             1,0,2,0,8'd255 & {8{EN[0]}}, 8'h33,32'hCAFE), 101);
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_memv", 64'(ifc.mem_v_o), 64'd0);
    chk("arst_frz", 64'(freeze_o), 64'd1);
    chk("arst_cr", 64'(credit_v_o), 64'd0);
    chk("arst_arb", 64'(arb_cfg_o), 64'd0);
    chk("arst_err", 64'(err_count_o), 64'd0);
    chk("arst_data", 64'(ifc.mem_data_o), 64'd0);
    @(negedge clk);
    drive(0, N, 0, 0, 0, 0);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cr", 64'(credit_v_o), 64'd0);
    chk("post_rst_memv", 64'(ifc.mem_v_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_pkt_exec.md
# bsg_manycore_pkt_exec

Executes packets already classified by the manycore packet decoder. Sits directly downstream of the decoder and consumes its one-hot class flags (freeze, unfreeze, arb-config, remote store, unknown) plus data, address and mask. It holds the tile freeze and arbitration-config registers, buffers one remote store towards the local memory port, and emits one credit per completed packet back to the network endpoint.

## Interface

Parameters:
- data_width_p, -1 (must be set), store/config data width
- addr_width_p, -1 (must be set), word address width
- arb_cfg_width_p, 2, width of arbitration config register, taken from data_i[arb_cfg_width_p-1:0]
- freeze_init_p, 1, freeze_o value at reset

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- v_i  in  1  decoded packet valid
- yumi_o  out  1  packet consumed this cycle
- pkt_freeze_i, pkt_unfreeze_i, pkt_arb_cfg_i, pkt_remote_store_i, pkt_unknown_i  in  1 each  decoder class flags, at most one high when v_i
- data_i  in  data_width_p  packet data
- addr_i  in  addr_width_p  packet address
- mask_i  in  data_width_p/8  byte mask for stores
- mem_v_o  out  1  store request valid
- mem_addr_o  out  addr_width_p  store address
- mem_data_o  out  data_width_p  store data
- mem_mask_o  out  data_width_p/8  store byte mask
- mem_yumi_i  in  1  memory accepts store; legal only when mem_v_o
- freeze_o  out  1  tile freeze state
- arb_cfg_o  out  arb_cfg_width_p  arbitration config
- credit_v_o  out  1  one-cycle pulse, one packet completed
- err_count_o  out  8  unknown-packet counter (see Configuration)

## Operation

- States: EMPTY (no buffered store), FULL (store buffered, mem_v_o=1).
- yumi_o = v_i & ( (EMPTY) | (FULL & mem_yumi_i & pkt_remote_store_i) ). Non-store packets are accepted only in EMPTY; a store may be accepted in the same cycle the buffered one drains.
- Store accepted: buffer loads addr_i/data_i/mask_i; next state FULL.
- FULL & mem_yumi_i & no new store accepted: next state EMPTY.
- Freeze accepted: freeze_o <= 1. Unfreeze accepted: freeze_o <= 0. If both flags high, freeze wins.
- Arb-config accepted: arb_cfg_o <= data_i[arb_cfg_width_p-1:0].
- Unknown accepted: dropped, no state change other than error counter; still credited.
- Credit sources: mem_yumi_i (store completion), or acceptance of any non-store packet. By the accept rule at most one per cycle; credit_v_o registered, high the cycle after the source event.
- v_i high with no flag set: treated as unknown.
- Outputs mem_addr_o/data_o/mask_o hold while FULL until mem_yumi_i; undefined-but-stable contents while EMPTY (driven from buffer register).

## Timing

- Reset (async assert, any state): state EMPTY, mem_v_o=0, freeze_o=freeze_init_p, arb_cfg_o=0, credit_v_o=0, err_count_o=0, buffer contents cleared to 0. A buffered store at reset is discarded, no credit.
- yumi_o combinational from v_i, flags, state, mem_yumi_i.
- Store accepted cycle t -> mem_v_o=1 at t+1 (earliest mem_yumi_i at t+1) -> credit_v_o at t+2 if yumi at t+1.
- Config accepted cycle t -> freeze_o/arb_cfg_o updated and credit_v_o high at t+1.
- Back-to-back stores with mem_yumi_i held high: one store per cycle, mem_v_o continuously high, one credit per cycle.

## Configuration

- BSG_MANYCORE_PKT_EXEC_ERR_CNT_EN defined: err_count_o is an 8-bit register incremented on each accepted unknown packet, saturating at 255, cleared by reset.
- Not defined: err_count_o tied to 0, no counter flops; all other behaviour identical.

## Test plan

- Reset with freeze_init_p=1 -> freeze_o=1, arb_cfg_o=0, mem_v_o=0, credit_v_o=0; unfreeze packet at cycle 2 -> yumi_o=1 at 2, freeze_o=0 and credit_v_o=1 at 3.
- Store addr=0x10, data=0xDEADBEEF, mask=0xF, mem_yumi_i held 0 for 3 cycles then 1 -> mem_v_o high 4 cycles with stable fields, single credit pulse cycle after yumi; second store offered meanwhile sees yumi_o=0 until the drain cycle.
- Four consecutive stores, mem_yumi_i always 1 -> yumi_o high 4 cycles, mem_v_o high 4 cycles, 4 credits in consecutive cycles.
- Store buffered (FULL), arb-config data=0x3 offered with mem_yumi_i=1 -> config not accepted that cycle; accepted next cycle, arb_cfg_o=3, total 2 credits on separate cycles.
- 300 unknown packets with macro defined -> err_count_o=255, 300 credits; without macro err_count_o=0.
- Assert reset_i mid-cycle while FULL -> mem_v_o drops immediately, no credit, freeze_o returns to freeze_init_p.
